// File: rtl/apb_master_pkg.sv
// Shared types and encodings for the APB read-modify-write master.
package apb_master_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_RMW_ADD = 2'b10,
    OP_RSVD    = 2'b11
  } apb_op_t;

  // Bus state kept as plain constants so older tools and netlists see fixed codes.
  typedef logic [1:0] apb_mst_state_t;
  localparam apb_mst_state_t ST_IDLE   = 2'd0;
  localparam apb_mst_state_t ST_SETUP  = 2'd1;
  localparam apb_mst_state_t ST_ACCESS = 2'd2;

  // Which half of an atomic add is on the bus.
  typedef logic apb_phase_t;
  localparam apb_phase_t RD_PHASE = 1'b0;
  localparam apb_phase_t WR_PHASE = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts PREADY-low ACCESS cycles; flags the cycle whose increment reaches TIMEOUT.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESET_N,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      // Timeout disabled: no storage, never expires.
      logic unused_ok;
      assign unused_ok = ^{PCLK, PRESET_N, clear, count_en};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt;

      // Wait-cycle counter, restarted each time ACCESS is entered.
      always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (count_en) begin
          cnt <= cnt + 1'b1;
        end
      end

      // Combinational so the abort lands on the same edge the count reaches TIMEOUT.
      assign expired = count_en && (cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_rmw_master.sv
// APB3 master with READ, WRITE and atomic read-add-write, fed by a valid/ready port.
//
//  state     | meaning
//  ST_IDLE   | bus idle, cmd_ready high, responses issued here
//  ST_SETUP  | PSEL=1 PENABLE=0, address/direction/data stable
//  ST_ACCESS | PSEL=1 PENABLE=1, waiting on PREADY or timeout
module apb_rmw_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  apb_mst_state_t    state;
  apb_phase_t        phase;
  apb_op_t           op_q;
  apb_op_t           cmd_op_e;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] old_q;
  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_expired;

  assign cmd_op_e  = apb_op_t'(cmd_op);
  assign cmd_ready = (state == ST_IDLE);
  assign PSEL      = (state != ST_IDLE);
  assign PENABLE   = (state == ST_ACCESS);

  // Timer restarts while in SETUP so it is zero on ACCESS entry.
  assign tmr_clear = (state == ST_SETUP);
  assign tmr_en    = (state == ST_ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .PCLK     (PCLK),
    .PRESET_N (PRESET_N),
    .clear    (tmr_clear),
    .count_en (tmr_en),
    .expired  (tmr_expired)
  );

  // Bus sequencing, command capture and response generation.
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state     <= ST_IDLE;
      phase     <= RD_PHASE;
      op_q      <= OP_READ;
      wdata_q   <= '0;
      old_q     <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op_e;
            wdata_q <= cmd_wdata;
            if (cmd_op_e == OP_RSVD) begin
              // Reserved op never reaches the bus.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state  <= ST_SETUP;
              phase  <= RD_PHASE;
              PADDR  <= cmd_addr;
              PWRITE <= (cmd_op_e == OP_WRITE);
              PWDATA <= (cmd_op_e == OP_WRITE) ? cmd_wdata : '0;
            end
          end
        end

        ST_SETUP: begin
          state <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            if ((op_q == OP_RMW_ADD) && (phase == RD_PHASE) && !PSLVERR) begin
              // Read half done: turn straight round into the write half.
              old_q  <= PRDATA;
              phase  <= WR_PHASE;
              state  <= ST_SETUP;
              PWRITE <= 1'b1;
              PWDATA <= PRDATA + wdata_q;
            end else begin
              state     <= ST_IDLE;
              PADDR     <= '0;
              PWRITE    <= 1'b0;
              PWDATA    <= '0;
              rsp_valid <= 1'b1;
              rsp_err   <= PSLVERR;
              if (op_q == OP_WRITE) begin
                rsp_data <= wdata_q;
              end else if (phase == WR_PHASE) begin
                rsp_data <= old_q;
              end else begin
                rsp_data <= PRDATA;
              end
            end
          end else if (tmr_expired) begin
            state     <= ST_IDLE;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rmw_master.sv
// Self-checking bench for apb_rmw_master: directed table, hand sequences, random vs model.
module tb_apb_rmw_master;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESET_N = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY = 1'b0;
  logic [31:0] PRDATA = '0;
  logic        PSLVERR = 1'b0;

  apb_rmw_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- slave model ----------------
  logic [31:0] slv_mem [logic [31:0]];
  int          slv_wait = 0;
  int          acc_n = 0;
  int          setup_n = 0;
  logic [31:0] last_wr = '1;

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : ~a;
  endfunction

  // Slave reacts on the falling edge; master samples on the next rising edge.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (acc_n >= slv_wait) begin
        PREADY  = 1'b1;
        PSLVERR = (PADDR[15:12] == 4'hE);
        PRDATA  = slv_rd(PADDR);
        if (PWRITE) begin
          last_wr = PWDATA;
          if (!PSLVERR) slv_mem[PADDR] = PWDATA;
        end
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
      acc_n++;
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      acc_n   = 0;
      if (PSEL) setup_n++;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ~a;
  endfunction

  task automatic ref_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                         input int w, output logic [31:0] ed, output logic ee, output int el);
    logic bad;
    logic [31:0] old;
    bad = (a[15:12] == 4'hE);
    if (op == 2'b11) begin
      ed = 0; ee = 1; el = 1;
    end else if (w >= TO) begin
      ed = 0; ee = 1; el = 2 + TO;
    end else if (op == 2'b00) begin
      ed = ref_rd(a); ee = bad; el = 3 + w;
    end else if (op == 2'b01) begin
      ed = d; ee = bad; el = 3 + w;
      if (!bad) ref_mem[a] = d;
    end else begin
      old = ref_rd(a);
      ed = old; ee = bad;
      if (bad) el = 3 + w;
      else begin
        el = 5 + 2 * w;
        ref_mem[a] = old + d;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                         input int w, output logic [31:0] rd, output logic re,
                         output int lat, output bit got);
    @(negedge PCLK);
    slv_wait  = w;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    got = 0; lat = 0; rd = 'x; re = 1'bx;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        got = 1; lat = i; rd = rsp_data; re = rsp_err;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_lat;
    int          exp_setups;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] rd, ed;
    logic        re, ee;
    int          lat, el, s0;
    bit          got;

    tbl[0]  = '{2'b00, 32'h1000, 32'h0,        0, 32'hDEADBEEF, 1'b0, 3, 1};
    tbl[1]  = '{2'b10, 32'h0020, 32'h1,        0, 32'hFFFFFFFF, 1'b0, 5, 2};
    tbl[2]  = '{2'b00, 32'h0020, 32'h0,        0, 32'h00000000, 1'b0, 3, 1};
    tbl[3]  = '{2'b00, 32'h1000, 32'h0,        7, 32'h00000000, 1'b1, 6, 1};
    tbl[4]  = '{2'b00, 32'h1000, 32'h0,        3, 32'hDEADBEEF, 1'b0, 6, 1};
    tbl[5]  = '{2'b01, 32'h0040, 32'h12345678, 1, 32'h12345678, 1'b0, 4, 1};
    tbl[6]  = '{2'b00, 32'h0040, 32'h0,        1, 32'h12345678, 1'b0, 4, 1};
    tbl[7]  = '{2'b11, 32'h0044, 32'h99,       0, 32'h00000000, 1'b1, 1, 0};
    tbl[8]  = '{2'b01, 32'hE010, 32'h55,       0, 32'h00000055, 1'b1, 3, 1};
    tbl[9]  = '{2'b10, 32'h0040, 32'h10,       2, 32'h12345678, 1'b0, 9, 2};
    tbl[10] = '{2'b00, 32'h0040, 32'h0,        0, 32'h12345688, 1'b0, 3, 1};
    tbl[11] = '{2'b10, 32'h0040, 32'h1,        4, 32'h00000000, 1'b1, 6, 1};
    tbl[12] = '{2'b00, 32'h0040, 32'h0,        0, 32'h12345688, 1'b0, 3, 1};
    tbl[13] = '{2'b10, 32'hE000, 32'h1,        0, 32'hFFFF1FFF, 1'b1, 3, 1};

    slv_mem[32'h1000] = 32'hDEADBEEF;
    slv_mem[32'h0020] = 32'hFFFFFFFF;

    // Reset values
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_bus_ctl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err}, 0);
    chk("rst_bus_data", {PADDR, PWDATA}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(negedge PCLK) PRESET_N = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      s0 = setup_n;
      run_cmd(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].waits, rd, re, lat, got);
      chk($sformatf("t%0d_rsp_seen", i), got, 1);
      chk($sformatf("t%0d_data", i), rd, tbl[i].exp_d);
      chk($sformatf("t%0d_err", i), re, tbl[i].exp_e);
      chk($sformatf("t%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("t%0d_setups", i), setup_n - s0, tbl[i].exp_setups);
      chk($sformatf("t%0d_psel_idle", i), {PSEL, PENABLE}, 0);
      if (i == 1) chk("rmw_wrap_pwdata", last_wr, 32'h0);
      @(negedge PCLK);
      chk($sformatf("t%0d_rsp_hold", i), {rsp_valid, rsp_err, rsp_data}, {1'b0, tbl[i].exp_e, tbl[i].exp_d});
    end

    // Back-to-back writes with cmd_valid held
    @(negedge PCLK);
    slv_wait = 0;
    cmd_valid = 1; cmd_op = 2'b01; cmd_addr = 32'h300; cmd_wdata = 32'hA1;
    @(posedge PCLK);
    #1 cmd_addr = 32'h304; cmd_wdata = 32'hB2;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("b2b_first_addr_held", {PENABLE, PADDR, PWDATA}, {1'b1, 32'h300, 32'hA1});
    @(negedge PCLK);
    chk("b2b_first_rsp", {rsp_valid, cmd_ready, rsp_data}, {1'b1, 1'b1, 32'hA1});
    @(posedge PCLK);
    #1 cmd_valid = 0;
    @(negedge PCLK);
    chk("b2b_second_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b101, 32'h304, 32'hB2});
    @(negedge PCLK);
    @(negedge PCLK);
    chk("b2b_second_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 32'hB2});

    // Reset during the write half of an RMW
    @(negedge PCLK);
    slv_wait = 2;
    cmd_valid = 1; cmd_op = 2'b10; cmd_addr = 32'h400; cmd_wdata = 32'h5;
    @(posedge PCLK);
    #1 cmd_valid = 0;
    repeat (6) @(negedge PCLK);
    chk("rst_mid_in_wr_access", {PSEL, PENABLE, PWRITE, PWDATA}, {3'b111, ~32'h400 + 32'h5});
    PRESET_N = 1'b0;
    #1;
    chk("rst_mid_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    @(negedge PCLK) PRESET_N = 1'b1;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      if (rsp_valid) got = 1;
    end
    chk("rst_mid_no_rsp", got, 0);
    run_cmd(2'b11, 32'h0, 32'h0, 0, rd, re, lat, got);
    chk("rsvd_after_rst", {got, re, rd}, {2'b11, 32'h0});

    // Random commands against the reference model
    for (int n = 0; n < 80; n++) begin
      logic [1:0]  op;
      logic [31:0] a, d;
      int          w;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: a = 32'h200;
        1: a = 32'h204;
        2: a = 32'h208;
        3: a = 32'hE000;
        default: a = 32'hE004;
      endcase
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = 32'hFFFFFFFF;
      w = $urandom_range(0, 5);
      ref_cmd(op, a, d, w, ed, ee, el);
      run_cmd(op, a, d, w, rd, re, lat, got);
      chk($sformatf("rnd%0d_rsp", n), {got, re, rd}, {1'b1, ee, ed});
      chk($sformatf("rnd%0d_latency", n), lat, el);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
